dcache_bus_bridge: RTL
======================

Name: dcache_bus_bridge

Overview:
Responder for the core's Mem-stage data-cache request interface. It accepts one load/store per request, aligns store data and byte enables, issues a single word-aligned transaction on a req/ack memory bus, and returns the extracted, sign- or zero-extended load data. It sits between the Mem stage and the data memory. While a bus transaction is outstanding it drives the Dcache stall request into Ctrl.

Parameters:
ADDR_WIDTH, 32, core/bus address width
DATA_WIDTH, 32, data width; fixed at 32, 4 byte lanes
TIMEOUT_CYCLES, 255, maximum cycles in BUS before the transaction is aborted; minimum 1

Ports:
clk  input  1  clock
rst_n  input  1  reset
Mem_DcacheEN  input  1  request valid; held stable by the core while Dcache_StallReq=1
Mem_DcacheRd  input  1  1=load, 0=store
Mem_DcacheWidth  input  2  00=byte, 01=half, 10=word, 11=reserved
Mem_DcacheAddr  input  ADDR_WIDTH  byte address
Mem_DcacheSign  input  1  1=sign-extend load, 0=zero-extend
EXMem_Rs2Data  input  DATA_WIDTH  store data, right-justified
Ctrl_MemStall  input  1  Mem stage held by Ctrl for another reason
Dcache_DataRd  output  DATA_WIDTH  formatted load data
Dcache_StallReq  output  1  stall request to Ctrl
Dcache_MisalignErr  output  1  misaligned or reserved-width request
Dcache_BusErr  output  1  bus timeout on the current request
Bus_Req  output  1  bus request
Bus_We  output  1  write strobe
Bus_Addr  output  ADDR_WIDTH  word address, bits [1:0]=0
Bus_WrData  output  DATA_WIDTH  lane-replicated store data
Bus_ByteEn  output  4  byte lane enables
Bus_Ack  input  1  single-cycle completion; Bus_RdData valid in the same cycle
Bus_RdData  input  DATA_WIDTH  read word

Behaviour:
Reset (asynchronous, active-low):
- clk is the only clock; rst_n is the asynchronous active-low reset.
- State goes to IDLE. All outputs and the capture registers are 0.
- Asserting rst_n mid-transaction drops Bus_Req immediately and abandons the transaction. A late Bus_Ack after reset is ignored.

Request decode (combinational):
- Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; width=11 at any address.
- Dcache_MisalignErr = Mem_DcacheEN & misaligned & state==IDLE.
- A misaligned request never issues a bus access and never raises a stall.

FSM states: IDLE, BUS, DONE.

IDLE:
- Dcache_StallReq = Mem_DcacheEN & aligned, combinational in the same cycle.
- On that condition: register Bus_Addr={addr[31:2],2'b00}, Bus_We=~Rd, byte enables, write data, lane offset, width and sign; clear the timeout counter; go to BUS.
- Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 0011 or 1100; word -> 1111. Loads use the same enables.
- Write data: byte -> {4{rs2[7:0]}}; half -> {2{rs2[15:0]}}; word -> rs2.

BUS:
- Bus_Req=1 with address, data and enables stable; Dcache_StallReq=1.
- On Bus_Ack: capture Bus_RdData (loads) and go to DONE.
- Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without ack: set the BusErr flag, captured data=0, go to DONE.
- Bus_Req deasserts on the clock edge that leaves BUS.

DONE:
- Bus_Req=0, Dcache_StallReq=0. Dcache_DataRd is valid; Dcache_BusErr is asserted if the timeout fired.
- Load data: lane selected by the registered offset; byte/half extended per Sign; word passed through. Stores return 0.
- If Ctrl_MemStall=1: stay in DONE, hold outputs, do not reissue. Otherwise go to IDLE.

Outside DONE: Dcache_DataRd=0 and Dcache_BusErr=0.

Latency: with ack in the first BUS cycle, the core is stalled exactly 2 cycles (IDLE, BUS) and data is presented in the 3rd cycle.

Simultaneous events:
- Mem_DcacheEN is only sampled in IDLE; changes in BUS or DONE are ignored.
- Ack and timeout in the same cycle: ack wins, no error.
- Back-to-back requests: each takes a full IDLE->BUS->DONE pass; there is no pipelining.

Test Plan:
- LB addr 0x1003, Sign=1, RdData 0x80AA55CC, ack after 1 cycle -> Bus_Addr 0x1000, ByteEn 1000, StallReq high 2 cycles, DataRd 0xFFFFFF80 in DONE.
- LHU addr 0x2002, RdData 0x8001_1234, ack delay 5 -> ByteEn 1100, StallReq high 6 cycles, DataRd 0x00008001.
- SB addr 0x3001, rs2 0x123456AB -> Bus_We=1, WrData 0xABABABAB, ByteEn 0010, DataRd 0; then SW addr 0x3004 -> ByteEn 1111, WrData = rs2.
- LW addr 0x4002 and LH addr 0x4001 -> MisalignErr=1 same cycle, Bus_Req never asserted, StallReq=0.
- TIMEOUT_CYCLES=4, no ack -> Bus_Req high 4 cycles, then DONE with BusErr=1, DataRd 0, StallReq released.
- Ctrl_MemStall=1 for 3 cycles in DONE -> DataRd held, a single Bus_Req total; rst_n pulse during BUS -> Bus_Req 0 immediately, state IDLE, all outputs 0.

Source files
------------

// File: rtl/dcache_bus_if.sv
// dcache_bus_if: req/ack data memory bus between the dcache bridge and memory
interface dcache_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  Bus_Req;
  logic                  Bus_We;
  logic [ADDR_WIDTH-1:0] Bus_Addr;
  logic [DATA_WIDTH-1:0] Bus_WrData;
  logic [3:0]            Bus_ByteEn;
  logic                  Bus_Ack;
  logic [DATA_WIDTH-1:0] Bus_RdData;
  modport master (output Bus_Req, Bus_We, Bus_Addr, Bus_WrData, Bus_ByteEn,
                  input  Bus_Ack, Bus_RdData);
  modport slave  (input  Bus_Req, Bus_We, Bus_Addr, Bus_WrData, Bus_ByteEn,
                  output Bus_Ack, Bus_RdData);
endinterface

// File: rtl/dcache_bus_bridge.sv
// dcache_bus_bridge: Mem-stage load/store to single-beat req/ack bus, with lane alignment and timeout
module dcache_bus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic                  Mem_DcacheSign,
  input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
  input  logic                  Ctrl_MemStall,
  output logic [DATA_WIDTH-1:0] Dcache_DataRd,
  output logic                  Dcache_StallReq,
  output logic                  Dcache_MisalignErr,
  output logic                  Dcache_BusErr,
  dcache_bus_if.master          bus
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d, sh;
  logic [1:0]            off_q, off_d, width_q, width_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  misaligned, launch;
  assign misaligned = Mem_DcacheWidth == 2'b11 ||
                      (Mem_DcacheWidth == 2'b01 && Mem_DcacheAddr[0]) ||
                      (Mem_DcacheWidth == 2'b10 && Mem_DcacheAddr[1:0] != 2'b00);
  assign launch = state_q == IDLE && Mem_DcacheEN && !misaligned;
  assign Dcache_MisalignErr = state_q == IDLE && Mem_DcacheEN && misaligned;
  assign Dcache_StallReq = launch || state_q == BUS;
  assign Dcache_BusErr = state_q == DONE && err_q;
  assign bus.Bus_Req = state_q == BUS;
  assign bus.Bus_We = we_q;
  assign bus.Bus_Addr = addr_q;
  assign bus.Bus_WrData = wdata_q;
  assign bus.Bus_ByteEn = be_q;
  // half offsets are always 0 or 2, so the same lane shift serves bytes and halves
  assign sh = data_q >> {off_q, 3'b000};
  assign Dcache_DataRd = state_q != DONE ? '0 :
                         width_q == 2'b00 ? {{24{sign_q & sh[7]}}, sh[7:0]} :
                         width_q == 2'b01 ? {{16{sign_q & sh[15]}}, sh[15:0]} : data_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    width_d = width_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    if (launch) begin
      state_d = BUS;
      addr_d  = {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
      we_d    = !Mem_DcacheRd;
      be_d    = Mem_DcacheWidth == 2'b00 ? 4'b0001 << Mem_DcacheAddr[1:0] :
                Mem_DcacheWidth == 2'b01 ? (Mem_DcacheAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_d = Mem_DcacheWidth == 2'b00 ? {4{EXMem_Rs2Data[7:0]}} :
                Mem_DcacheWidth == 2'b01 ? {2{EXMem_Rs2Data[15:0]}} : EXMem_Rs2Data;
      off_d   = Mem_DcacheAddr[1:0];
      width_d = Mem_DcacheWidth;
      sign_d  = Mem_DcacheSign;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == BUS) begin
      // ack takes priority over a timeout landing in the same cycle
      if (bus.Bus_Ack) begin
        state_d = DONE;
        data_d  = we_q ? '0 : bus.Bus_RdData;
      end else if (cnt_q == LAST) begin
        state_d = DONE;
        data_d  = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q != IDLE && !(state_q == DONE && Ctrl_MemStall)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      width_q <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      width_q <= width_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule
